pc_control_seq: RTL and testbench
=================================

# pc_control_seq

Registered program-counter unit for the single-issue WISC core. Holds the architectural PC and the Z/V/N flag register, evaluates all eight branch conditions for B (PC-relative) and BR (register) instructions, and advances the PC each cycle unless stalled or halted. Detects HLT and parks the core. Keeps a saturating count of taken branches for the perf/debug port. It generalises the former combinational next-PC logic in width, reset vector and step size, and adds state.

## Interface
Parameters:
- PC_WIDTH, 16, width of PC, targets and branch_reg_addr
- IMM_WIDTH, 9, B-immediate width taken from instr[IMM_WIDTH-1:0]; legal range 1..9
- INSTR_BYTES, 2, sequential PC increment
- RESET_VECTOR, 0, PC value after reset
- CNT_WIDTH, 16, width of taken-branch counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC, flags and counter this cycle
- instr  in  16  instruction at current pc: [15:12] opcode, [11:9] cond, [IMM_WIDTH-1:0] imm
- branch_reg_addr  in  PC_WIDTH  rs data, target for BR
- flag_wr_en  in  3  per-flag write enable {Z,V,N}
- flag_in  in  3  new flag values {Z,V,N}
- pc  out  PC_WIDTH  current PC (registered)
- pc_plus  out  PC_WIDTH  pc + INSTR_BYTES (combinational, used by PCS)
- taken  out  1  current instruction is a taken B/BR (combinational)
- flags  out  3  registered {Z,V,N}
- halted  out  1  registered; 1 in HALT state
- taken_cnt  out  CNT_WIDTH  saturating taken-branch count

## Operation
- Opcodes: B = 4'b1100, BR = 4'b1101, HLT = 4'b1111; all others are sequential.
- Conditions are evaluated on the registered flags (Z = flags[2], V = flags[1], N = flags[0]):
  - 000 NE: Z=0.
  - 001 EQ: Z=1.
  - 010 GT: Z=0 and N=0.
  - 011 LT: N=1.
  - 100 GTE: Z=1 or (Z=0 and N=0).
  - 101 LTE: N=1 or Z=1.
  - 110 OV: V=1.
  - 111 always.
- taken = (opcode is B or BR) and cond true and state RUN.
- Targets:
  - B target = pc_plus + (sign_extend(imm) << 1), truncated mod 2^PC_WIDTH.
  - BR target = branch_reg_addr, used verbatim.
- Next PC is selected in priority order:
  - rst → RESET_VECTOR.
  - HALT state or stall → pc.
  - HLT opcode → pc.
  - taken → target.
  - Otherwise → pc_plus.
- The PC wraps modulo 2^PC_WIDTH, both for sequential increment and for branch targets.
- States:
  - RUN: default after reset. HLT decoded while not stalled → HALT at the next edge. A stalled HLT stays in RUN.
  - HALT: pc, flags and taken_cnt frozen; halted=1. Only rst leaves HALT.
- Flags:
  - Each bit i updates to flag_in[i] when flag_wr_en[i]=1, state is RUN, and stall=0.
  - Other bits hold.
  - A flag write and a branch in the same cycle is legal: the branch uses the old flags, and the new flags are visible next cycle.
- taken_cnt increments when taken=1 and stall=0, and saturates at all-ones.

## Timing
- Reset values after a clock edge with rst=1: pc=RESET_VECTOR, flags=3'b000, halted=0, taken_cnt=0, state RUN. rst overrides stall and HALT.
- Latency:
  - Next PC is visible 1 cycle after the instruction is presented.
  - halted rises 1 cycle after HLT is accepted.
  - flags are visible 1 cycle after the write.
- pc_plus and taken are purely combinational from pc, instr and flags, with no added register stage.
- Stall:
  - Stall held for N cycles freezes all state for N edges.
  - On stall release, the same instruction is re-evaluated.
- Reset asserted mid-HALT or mid-stall returns to RUN at RESET_VECTOR at that edge.

## Test plan
- Reset and sequential fetch: rst for 2 cycles, RESET_VECTOR=0, NOP stream → pc=0, 2, 4, 6 on consecutive edges; flags=000, taken_cnt=0.
- B with all conditions:
  - For each cond, test a flag setting that makes it true (target pc_plus+2 with imm=1) and one that makes it false (pc_plus).
  - Example: pc=0x0010, cond=010, Z=0, N=0, imm=1 → pc=0x0014.
  - Negative imm=9'h1FF at pc=0x0010 → 0x0010.
- BR: opcode 1101, cond 111, branch_reg_addr=0x000F → pc=0x000F next edge, taken_cnt increments by 1.
- Flag write/branch collision: write Z=1 (flag_wr_en=100) while an EQ branch is presented with Z=0 → not taken. The next EQ branch is taken. Bits V and N remain unchanged.
- Stall and HLT:
  - Stall 3 cycles during a taken B → pc and taken_cnt frozen, then the branch is taken once.
  - HLT → halted=1 the next cycle and pc frozen over 10 cycles.
  - rst mid-HALT → pc=RESET_VECTOR, halted=0.
- Wrap and saturation:
  - pc=0xFFFE sequential → pc=0x0000.
  - CNT_WIDTH=2 with 5 taken branches → taken_cnt=3.

Source files
------------

// File: rtl/pc_control_seq.sv
// Registered program-counter unit: holds PC, Z/V/N flags and a saturating
// taken-branch count, resolves B/BR branches and parks the core on HLT.
module pc_control_seq #(
  parameter int PC_WIDTH     = 16,
  parameter int IMM_WIDTH    = 9,
  parameter int INSTR_BYTES  = 2,
  parameter int RESET_VECTOR = 0,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic [15:0]          instr,
  input  logic [PC_WIDTH-1:0]  branch_reg_addr,
  input  logic [2:0]           flag_wr_en,
  input  logic [2:0]           flag_in,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [PC_WIDTH-1:0]  pc_plus,
  output logic                 taken,
  output logic [2:0]           flags,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] taken_cnt
);

  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;
  localparam int EXT_W = PC_WIDTH - IMM_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [2:0]           flags_q, flags_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [3:0]           opcode_s;
  logic [2:0]           cond_s;
  logic [IMM_WIDTH-1:0] imm_s;
  logic [PC_WIDTH-1:0]  imm_ext_s;
  logic [PC_WIDTH-1:0]  pc_plus_s;
  logic [PC_WIDTH-1:0]  target_s;
  logic                 is_branch_s;
  logic                 is_hlt_s;
  logic                 cond_ok_s;
  logic                 taken_s;

  // Flag layout is {Z,V,N}; GTE is written literally as "EQ or GT".
  function automatic logic cond_true(input logic [2:0] cond, input logic [2:0] f);
    logic z;
    logic v;
    logic n;
    logic r;
    z = f[2];
    v = f[1];
    n = f[0];
    case (cond)
      3'b000:  r = ~z;
      3'b001:  r = z;
      3'b010:  r = ~z & ~n;
      3'b011:  r = n;
      3'b100:  r = z | (~z & ~n);
      3'b101:  r = n | z;
      3'b110:  r = v;
      3'b111:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Decode, branch condition and target computation (all off registered state)
  always_comb begin
    opcode_s    = instr[15:12];
    cond_s      = instr[11:9];
    imm_s       = instr[IMM_WIDTH-1:0];
    imm_ext_s   = {{EXT_W{imm_s[IMM_WIDTH-1]}}, imm_s};
    pc_plus_s   = pc_q + PC_WIDTH'(INSTR_BYTES);
    is_branch_s = (opcode_s == OP_B) || (opcode_s == OP_BR);
    is_hlt_s    = (opcode_s == OP_HLT);
    cond_ok_s   = cond_true(cond_s, flags_q);
    taken_s     = is_branch_s && cond_ok_s && (state_q == ST_RUN);
    if (opcode_s == OP_BR) begin
      target_s = branch_reg_addr;
    end else begin
      target_s = pc_plus_s + {imm_ext_s[PC_WIDTH-2:0], 1'b0};
    end
  end

  // Next-state for PC, flags, counter and RUN/HALT
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (!stall) begin
          for (int i = 0; i < 3; i++) begin
            if (flag_wr_en[i]) begin
              flags_d[i] = flag_in[i];
            end else begin
              flags_d[i] = flags_q[i];
            end
          end
          if (is_hlt_s) begin
            state_d = ST_HALT;
            pc_d    = pc_q;
          end else if (taken_s) begin
            pc_d = target_s;
          end else begin
            pc_d = pc_plus_s;
          end
          if (taken_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State registers; reset overrides stall and HALT
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= PC_WIDTH'(RESET_VECTOR);
      flags_q <= 3'b000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc        = pc_q;
  assign pc_plus   = pc_plus_s;
  assign taken     = taken_s;
  assign flags     = flags_q;
  assign halted    = (state_q == ST_HALT);
  assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_pc_control_seq.sv
// Scoreboard bench for pc_control_seq: directed scenarios plus random traffic
// against a behavioural model; a second instance with CNT_WIDTH=2 checks saturation.
module tb_pc_control_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic [15:0] bra = 16'h0000;
  logic [2:0]  fwe = 3'b000;
  logic [2:0]  fin = 3'b000;

  logic [15:0] pc, pc_plus, cnt;
  logic        taken, halted;
  logic [2:0]  flags;
  logic [15:0] pc2, pc_plus2;
  logic        taken2, halted2;
  logic [2:0]  flags2;
  logic [1:0]  cnt2;

  pc_control_seq dut (
    .clk(clk), .rst(rst), .stall(stall), .instr(instr), .branch_reg_addr(bra),
    .flag_wr_en(fwe), .flag_in(fin), .pc(pc), .pc_plus(pc_plus), .taken(taken),
    .flags(flags), .halted(halted), .taken_cnt(cnt)
  );

  pc_control_seq #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .instr(instr), .branch_reg_addr(bra),
    .flag_wr_en(fwe), .flag_in(fin), .pc(pc2), .pc_plus(pc_plus2), .taken(taken2),
    .flags(flags2), .halted(halted2), .taken_cnt(cnt2)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [2:0]  fl;
    logic        h;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } st_t;

  typedef struct packed {
    logic [15:0] pp;
    logic        tk;
  } comb_t;

  st_t   sq[$];
  comb_t cq[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model state
  int        m_pc = 0;
  logic [2:0] m_fl = 3'b000;
  bit        m_halt = 1'b0;
  int        m_cnt = 0;
  int        hcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Branch conditions in terms of the flag meanings {Z,V,N}
  function automatic bit model_cond(input int c, input logic [2:0] f);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || !n;
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic step(input bit r, input bit s, input logic [15:0] ins,
                      input logic [15:0] ba, input logic [2:0] we, input logic [2:0] fi);
    int    op, imm, pp, tgt;
    bit    tk;
    st_t   e;
    comb_t c;
    @(negedge clk);
    rst = r; stall = s; instr = ins; bra = ba; fwe = we; fin = fi;
    op  = int'(ins[15:12]);
    pp  = (m_pc + 2) % 65536;
    tk  = (op == 12 || op == 13) && model_cond(int'(ins[11:9]), m_fl) && !m_halt;
    imm = int'(ins[8:0]);
    if (imm >= 256) imm = imm - 512;
    if (op == 13) tgt = int'(ba);
    else tgt = (((pp + 2 * imm) % 65536) + 65536) % 65536;
    if (!r) begin
      c.pp = pp[15:0];
      c.tk = tk;
      cq.push_back(c);
    end
    if (r) begin
      m_pc = 0; m_fl = 3'b000; m_halt = 1'b0; m_cnt = 0;
    end else if (!m_halt && !s) begin
      for (int i = 0; i < 3; i++) if (we[i]) m_fl[i] = fi[i];
      if (op == 15) m_halt = 1'b1;
      else if (tk) begin
        m_pc = tgt;
        m_cnt++;
      end else m_pc = pp;
    end
    if (m_halt) hcnt++; else hcnt = 0;
    e.pc   = m_pc[15:0];
    e.fl   = m_fl;
    e.h    = m_halt;
    e.cnt  = (m_cnt > 65535) ? 16'hFFFF : m_cnt[15:0];
    e.cnt2 = (m_cnt > 3) ? 2'd3 : m_cnt[1:0];
    sq.push_back(e);
  endtask

  // Monitor: registered state, one edge after the stimulus was applied
  initial begin
    st_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sq.size() > 0) begin
        e = sq.pop_front();
        chk("pc", 32'(pc), 32'(e.pc));
        chk("pc_sat", 32'(pc2), 32'(e.pc));
        chk("flags", 32'(flags), 32'(e.fl));
        chk("flags_sat", 32'(flags2), 32'(e.fl));
        chk("halted", 32'(halted), 32'(e.h));
        chk("halted_sat", 32'(halted2), 32'(e.h));
        chk("taken_cnt", 32'(cnt), 32'(e.cnt));
        chk("taken_cnt_sat", 32'(cnt2), 32'(e.cnt2));
      end
    end
  end

  // Monitor: combinational outputs once the new inputs have settled
  initial begin
    comb_t c;
    forever begin
      @(negedge clk);
      #2;
      if (cq.size() > 0) begin
        c = cq.pop_front();
        chk("pc_plus", 32'(pc_plus), 32'(c.pp));
        chk("pc_plus_sat", 32'(pc_plus2), 32'(c.pp));
        chk("taken", 32'(taken), 32'(c.tk));
        chk("taken_sat", 32'(taken2), 32'(c.tk));
      end
    end
  end

  localparam logic [15:0] NOP = 16'h0000;

  initial begin
    logic [2:0]  p;
    logic [15:0] ins;
    bit          found;
    // Reset and sequential fetch
    step(1'b1, 1'b0, NOP, 16'h0, 3'b000, 3'b000);
    step(1'b1, 1'b0, NOP, 16'h0, 3'b000, 3'b000);
    repeat (4) step(1'b0, 1'b0, NOP, 16'h0, 3'b000, 3'b000);

    // Every condition true and false with imm=1, branch issued at pc=0x0010
    for (int c = 0; c < 8; c++) begin
      for (int t = 0; t < 2; t++) begin
        found = 1'b0;
        p = 3'b000;
        for (int k = 0; k < 8; k++) begin
          if (!found && model_cond(c, 3'(k)) == (t == 0)) begin
            p = 3'(k);
            found = 1'b1;
          end
        end
        if (found) begin
          step(1'b0, 1'b0, 16'hDE00, 16'h000E, 3'b000, 3'b000);
          step(1'b0, 1'b0, NOP, 16'h0, 3'b111, p);
          ins = {4'hC, 3'(c), 9'h001};
          step(1'b0, 1'b0, ins, 16'h0, 3'b000, 3'b000);
        end
      end
    end
    // Negative immediate
    step(1'b0, 1'b0, 16'hDE00, 16'h000E, 3'b000, 3'b000);
    step(1'b0, 1'b0, NOP, 16'h0, 3'b000, 3'b000);
    step(1'b0, 1'b0, 16'hCFFF, 16'h0, 3'b000, 3'b000);
    // BR always
    step(1'b0, 1'b0, 16'hDE00, 16'h000F, 3'b000, 3'b000);
    // Flag write colliding with EQ branch, then EQ taken
    step(1'b0, 1'b0, NOP, 16'h0, 3'b111, 3'b000);
    step(1'b0, 1'b0, 16'hC201, 16'h0, 3'b100, 3'b100);
    step(1'b0, 1'b0, 16'hC201, 16'h0, 3'b000, 3'b000);
    // Stall during a taken branch
    repeat (3) step(1'b0, 1'b1, 16'hCE01, 16'h0, 3'b000, 3'b000);
    step(1'b0, 1'b0, 16'hCE01, 16'h0, 3'b000, 3'b000);
    // Stalled HLT stays in RUN
    step(1'b0, 1'b1, 16'hF000, 16'h0, 3'b000, 3'b000);
    step(1'b0, 1'b0, NOP, 16'h0, 3'b000, 3'b000);
    // HLT, frozen for 10 cycles, then reset out of HALT
    step(1'b0, 1'b0, 16'hF000, 16'h0, 3'b000, 3'b000);
    repeat (10) step(1'b0, 1'b0, 16'hCE01, 16'h1234, 3'b111, 3'b111);
    step(1'b1, 1'b0, NOP, 16'h0, 3'b000, 3'b000);
    // PC wrap
    step(1'b0, 1'b0, 16'hDE00, 16'hFFFE, 3'b000, 3'b000);
    step(1'b0, 1'b0, NOP, 16'h0, 3'b000, 3'b000);
    step(1'b0, 1'b0, NOP, 16'h0, 3'b000, 3'b000);

    // Random traffic
    repeat (800) begin
      int sel;
      bit r;
      sel = int'($urandom_range(0, 9));
      ins = 16'($urandom);
      case (sel)
        0, 1, 2: ins[15:12] = 4'hC;
        3:       ins[15:12] = 4'hD;
        4:       ins[15:12] = ($urandom_range(0, 3) == 0) ? 4'hF : 4'h0;
        default: ins[15:12] = 4'($urandom_range(0, 11));
      endcase
      r = ($urandom_range(0, 99) < 2) || (m_halt && hcnt > 6);
      step(r, ($urandom_range(0, 4) == 0), ins, 16'($urandom), 3'($urandom), 3'($urandom));
    end

    repeat (3) @(posedge clk);
    #3;
    if (sq.size() != 0 || cq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: actual %0d pending required 0", sq.size() + cq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
